mmio_timer_slave: RTL and testbench

- Memory-mapped timer/counter peripheral that responds to the core's data-memory bus as a slave, alongside RAM and UART, on the memory-map slave side.
- Takes address, write data and write/read selects from the map and returns read data.
- Runs a prescaled 32-bit up-counter with a compare match, auto-reload and an interrupt output.
- The pipeline cannot stall, so every bus access completes in the same cycle.

---
 rtl/mmio_timer_slave.sv | 96 +++++++++
 tb/tb_mmio_timer_slave.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_slave.sv
// Memory-mapped prescaled 32-bit timer slave: single-cycle bus reads/writes,
// compare match with optional auto-reload and a level interrupt.
module mmio_timer_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic [DATA_WIDTH-1:0] address,
   input  logic                  we,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] rd,
   output logic                  irq
);

   logic [2:0]            ctrl_q, ctrl_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           compare_q, compare_d;
   logic                  match_q, match_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] ps_cnt_q, ps_cnt_d;

   logic [2:0] idx;
   logic       wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
   logic       tick, hit;
   logic       unused_addr;

   assign idx         = address[4:2];
   assign unused_addr = ^{address[DATA_WIDTH-1:ADDR_WIDTH], address[ADDR_WIDTH-1:5], address[1:0]};

   always_comb begin
      wr_ctrl     = we && (idx == 3'd0);
      wr_count    = we && (idx == 3'd1);
      wr_compare  = we && (idx == 3'd2);
      wr_status   = we && (idx == 3'd3);
      wr_prescale = we && (idx == 3'd4);
      hit         = (count_q == compare_q);
      // A CTRL write that clears EN freezes COUNT, so it also swallows this cycle's tick.
      tick        = ctrl_q[0] && (ps_cnt_q == prescale_q) && !(wr_ctrl && !wd[0]);

      ctrl_d     = wr_ctrl    ? wd[2:0]            : ctrl_q;
      compare_d  = wr_compare ? wd                 : compare_q;
      prescale_d = wr_prescale ? wd[PRESCALE_W-1:0] : prescale_q;

      ps_cnt_d = ps_cnt_q;
      if (!ctrl_q[0] || (ps_cnt_q == prescale_q)) ps_cnt_d = '0;
      else                                         ps_cnt_d = ps_cnt_q + PRESCALE_W'(1);
      if (wr_prescale) ps_cnt_d = '0;

      count_d = count_q;
      if (tick) count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
      if (wr_count) count_d = wd;

      // Set by a match tick takes priority over a same-cycle W1C.
      match_d = match_q;
      if (wr_status && wd[0]) match_d = 1'b0;
      if (tick && hit)        match_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q     <= '0;
         count_q    <= '0;
         compare_q  <= 32'hFFFF_FFFF;
         match_q    <= 1'b0;
         prescale_q <= '0;
         ps_cnt_q   <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         match_q    <= match_d;
         prescale_q <= prescale_d;
         ps_cnt_q   <= ps_cnt_d;
      end
   end

   always_comb begin
      rd = '0;
      if (re) begin
         case (idx)
            3'd0:    rd = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
            3'd1:    rd = count_q;
            3'd2:    rd = compare_q;
            3'd3:    rd = {{(DATA_WIDTH-1){1'b0}}, match_q};
            3'd4:    rd = {{(DATA_WIDTH-PRESCALE_W){1'b0}}, prescale_q};
            default: rd = '0;
         endcase
      end
   end

   assign irq = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Directed bench for mmio_timer_slave; expected values queued at stimulus time, popped at check time.
module tb_mmio_timer_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wd = '0;
   logic [31:0] address = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] rd;
   logic        irq;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   mmio_timer_slave dut (
      .clk(clk), .rst(rst), .wd(wd), .address(address),
      .we(we), .re(re), .rd(rd), .irq(irq)
   );

   always #10 clk = ~clk;

   // All task calls start at a negedge; wr consumes exactly one rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1; address = a; wd = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic compare_out(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      e = exp_q.pop_front();
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      re = 1'b1; address = a;
      #1;
      compare_out(tag, rd);
      re = 1'b0;
   endtask

   task automatic irq_chk(input logic e, input string tag);
      exp_q.push_back({31'd0, e});
      #1;
      compare_out(tag, {31'd0, irq});
   endtask

   initial begin
      idle(2);
      rst = 1'b0;

      // reset state
      rd_chk(32'h00, 32'h0, "rst_ctrl");
      rd_chk(32'h04, 32'h0, "rst_count");
      rd_chk(32'h08, 32'hFFFF_FFFF, "rst_compare");
      rd_chk(32'h0C, 32'h0, "rst_status");
      rd_chk(32'h10, 32'h0, "rst_prescale");
      rd_chk(32'h14, 32'h0, "rst_0x14");
      irq_chk(1'b0, "rst_irq");

      // auto-reload match with interrupt
      wr(32'h10, 0);
      wr(32'h08, 5);
      wr(32'h00, 7);
      idle(5);
      rd_chk(32'h04, 5, "ar_count5");
      rd_chk(32'h0C, 0, "ar_status_pre");
      idle(1);
      rd_chk(32'h04, 0, "ar_reload");
      rd_chk(32'h0C, 1, "ar_status");
      irq_chk(1'b1, "ar_irq");
      wr(32'h0C, 1);
      irq_chk(1'b0, "w1c_irq");
      rd_chk(32'h0C, 0, "w1c_status");
      rd_chk(32'h04, 1, "ar_count1");
      wr(32'h00, 0);
      rd_chk(32'h04, 1, "stop_count");

      // prescale 3: one increment every 4 cycles
      wr(32'h04, 0);
      wr(32'h10, 3);
      wr(32'h00, 1);
      idle(40);
      rd_chk(32'h04, 10, "ps_count10");
      rd_chk(32'h10, 3, "ps_reg");
      wr(32'h00, 0);
      idle(3);
      rd_chk(32'h04, 10, "ps_frozen");

      // wrap, then non-reload match at COMPARE=0
      wr(32'h0C, 1);
      wr(32'h10, 0);
      wr(32'h08, 0);
      wr(32'h04, 32'hFFFF_FFFE);
      wr(32'h00, 1);
      rd_chk(32'h04, 32'hFFFF_FFFE, "wrap_start");
      idle(1);
      rd_chk(32'h04, 32'hFFFF_FFFF, "wrap_max");
      rd_chk(32'h0C, 0, "wrap_status_a");
      idle(1);
      rd_chk(32'h04, 0, "wrap_zero");
      rd_chk(32'h0C, 0, "wrap_status_b");
      idle(1);
      rd_chk(32'h04, 1, "nr_count1");
      rd_chk(32'h0C, 1, "nr_status");
      wr(32'h00, 0);

      // bus write to COUNT on a match tick
      wr(32'h0C, 1);
      wr(32'h08, 3);
      wr(32'h04, 3);
      wr(32'h00, 1);
      wr(32'h04, 32'h100);
      rd_chk(32'h04, 32'h100, "col_count");
      rd_chk(32'h0C, 1, "col_status");
      wr(32'h00, 0);
      rd_chk(32'h04, 32'h100, "col_frozen");

      // W1C on a match tick
      wr(32'h0C, 1);
      rd_chk(32'h0C, 0, "w1c_pre");
      wr(32'h04, 3);
      wr(32'h00, 1);
      wr(32'h0C, 1);
      rd_chk(32'h0C, 1, "w1c_vs_match");
      wr(32'h00, 0);

      // reset mid-state
      wr(32'h04, 7);
      wr(32'h00, 4);
      rd_chk(32'h04, 7, "pre_rst_count");
      rd_chk(32'h0C, 1, "pre_rst_status");
      irq_chk(1'b1, "pre_rst_irq");
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      rd_chk(32'h00, 0, "mid_rst_ctrl");
      rd_chk(32'h04, 0, "mid_rst_count");
      rd_chk(32'h08, 32'hFFFF_FFFF, "mid_rst_compare");
      rd_chk(32'h0C, 0, "mid_rst_status");
      rd_chk(32'h10, 0, "mid_rst_prescale");
      irq_chk(1'b0, "mid_rst_irq");

      // read during write returns old value
      exp_q.push_back(32'hFFFF_FFFF);
      we = 1'b1; re = 1'b1; address = 32'h08; wd = 32'h1234;
      #1;
      compare_out("rdw_old", rd);
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      rd_chk(32'h08, 32'h1234, "rdw_new");

      // unmapped offset
      wr(32'h18, 32'hDEAD_BEEF);
      rd_chk(32'h18, 0, "unmapped_rd");
      rd_chk(32'h08, 32'h1234, "unmapped_compare");
      rd_chk(32'h00, 0, "unmapped_ctrl");
      rd_chk(32'h04, 0, "unmapped_count");
      rd_chk(32'h0C, 0, "unmapped_status");
      rd_chk(32'h10, 0, "unmapped_prescale");

      // no read select drives zero
      exp_q.push_back(32'h0);
      re = 1'b0; address = 32'h08;
      #1;
      compare_out("re_low", rd);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
